dac_wave_seq: RTL and testbench

DAC_WAVE_SEQ -- requirements
Module: dac_wave_seq

---
 rtl/dac_wave_seq.sv | 153 +++++++++++++++
 tb/tb_dac_wave_seq.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/dac_wave_seq.sv
// DAC waveform sequencer: sawtooth/triangle/square/hold generator paced by val_req,
// with an active config and a one-entry pending config swapped in at period boundaries.
module dac_wave_seq #(
  parameter int DAC_BITS = 14
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                run,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [1:0]          cfg_mode,
  input  logic [DAC_BITS-1:0] cfg_lo,
  input  logic [DAC_BITS-1:0] cfg_hi,
  input  logic [DAC_BITS-1:0] cfg_step,
  input  logic                val_req,
  output logic [DAC_BITS-1:0] dac_val,
  output logic                busy,
  output logic                period_done,
  output logic                cfg_err
);
  typedef enum logic [1:0] {IDLE, UP, DOWN, HOLD} state_t;
  typedef struct packed {
    logic [1:0]          mode;
    logic [DAC_BITS-1:0] lo;
    logic [DAC_BITS-1:0] hi;
    logic [DAC_BITS-1:0] step;
  } cfg_t;

  state_t              state, nxt_state;
  cfg_t                act, pend, in_cfg;
  logic                p_vld;
  logic [DAC_BITS-1:0] sq_cnt, nxt_cnt, nxt_val;
  logic [DAC_BITS:0]   sum, dif;
  logic                pd;

  assign in_cfg    = '{mode: cfg_mode, lo: cfg_lo, hi: cfg_hi, step: cfg_step};
  assign cfg_ready = ~p_vld;
  assign busy      = (state != IDLE);

  // One val_req step; extra MSB on sum/dif catches overflow and underflow.
  always_comb begin
    sum       = {1'b0, dac_val} + {1'b0, act.step};
    dif       = {1'b0, dac_val} - {1'b0, act.step};
    nxt_val   = dac_val;
    nxt_state = state;
    nxt_cnt   = sq_cnt;
    pd        = 1'b0;
    case (state)
      HOLD: begin
        nxt_val = act.lo;
        pd      = 1'b1;
      end
      UP, DOWN: begin
        case (act.mode)
          2'd1: if (act.step != '0) begin
            if (sum > {1'b0, act.hi}) begin
              nxt_val = act.lo;
              pd      = 1'b1;
            end else begin
              nxt_val = sum[DAC_BITS-1:0];
            end
          end
          2'd2: if (act.step != '0) begin
            if (state == UP) begin
              if (sum >= {1'b0, act.hi}) begin
                nxt_val   = act.hi;
                nxt_state = DOWN;
              end else begin
                nxt_val = sum[DAC_BITS-1:0];
              end
            end else if (dif[DAC_BITS] || dif[DAC_BITS-1:0] <= act.lo) begin
              nxt_val   = act.lo;
              nxt_state = UP;
              pd        = 1'b1;
            end else begin
              nxt_val = dif[DAC_BITS-1:0];
            end
          end
          2'd3: begin
            // Square: UP means output sits at lo, DOWN means it sits at hi.
            if (sq_cnt == act.step) begin
              nxt_cnt = '0;
              if (state == UP) begin
                nxt_val   = act.hi;
                nxt_state = DOWN;
              end else begin
                nxt_val   = act.lo;
                nxt_state = UP;
                pd        = 1'b1;
              end
            end else begin
              nxt_cnt = sq_cnt + 1'b1;
            end
          end
          default: begin
            nxt_val = act.lo;
            pd      = 1'b1;
          end
        endcase
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      dac_val     <= '0;
      period_done <= 1'b0;
      cfg_err     <= 1'b0;
      p_vld       <= 1'b0;
      pend        <= '0;
      act         <= '{mode: 2'd0, lo: '0, hi: '1, step: DAC_BITS'(1)};
      sq_cnt      <= '0;
    end else begin
      period_done <= 1'b0;
      cfg_err     <= 1'b0;
      if (cfg_valid && cfg_ready) begin
        if (cfg_lo > cfg_hi) begin
          cfg_err <= 1'b1;
        end else if (state == IDLE) begin
          act <= in_cfg;
        end else begin
          pend  <= in_cfg;
          p_vld <= 1'b1;
        end
      end
      if (state == IDLE) begin
        if (run) begin
          dac_val <= act.lo;
          state   <= (act.mode == 2'd0) ? HOLD : UP;
          sq_cnt  <= '0;
        end
      end else if (!run) begin
        state <= IDLE;
      end else if (val_req) begin
        period_done <= pd;
        if (pd && p_vld) begin
          // Period boundary with a queued config: restart on the new one.
          act     <= pend;
          p_vld   <= 1'b0;
          dac_val <= pend.lo;
          state   <= (pend.mode == 2'd0) ? HOLD : UP;
          sq_cnt  <= '0;
        end else begin
          dac_val <= nxt_val;
          state   <= nxt_state;
          sq_cnt  <= nxt_cnt;
        end
      end
    end
  end
endmodule

// File: tb/tb_dac_wave_seq.sv
// Directed bench for dac_wave_seq: sample at negedge, drive after negedge.
module tb_dac_wave_seq;
  logic        clk, rst, run, cfg_valid, cfg_ready, val_req;
  logic [1:0]  cfg_mode;
  logic [13:0] cfg_lo, cfg_hi, cfg_step, dac_val;
  logic        busy, period_done, cfg_err;
  int          checks = 0, failures = 0;

  dac_wave_seq #(.DAC_BITS(14)) dut (
    .clk(clk), .rst(rst), .run(run), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_mode(cfg_mode), .cfg_lo(cfg_lo), .cfg_hi(cfg_hi), .cfg_step(cfg_step),
    .val_req(val_req), .dac_val(dac_val), .busy(busy), .period_done(period_done),
    .cfg_err(cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_req();
    val_req = 1'b1;
    tick();
    val_req = 1'b0;
  endtask

  task automatic set_cfg(input logic [1:0] m, input logic [13:0] l, input logic [13:0] h,
                         input logic [13:0] s);
    cfg_mode = m; cfg_lo = l; cfg_hi = h; cfg_step = s;
  endtask

  task automatic send_cfg(input logic [1:0] m, input logic [13:0] l, input logic [13:0] h,
                          input logic [13:0] s);
    set_cfg(m, l, h, s);
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
  endtask

  logic [13:0] tri_exp [6] = '{14'h1700, 14'h1E00, 14'h2000, 14'h1900, 14'h1200, 14'h1000};
  logic [13:0] sq_exp  [9] = '{14'h0100, 14'h0100, 14'h3F00, 14'h3F00, 14'h3F00,
                               14'h0100, 14'h0100, 14'h0100, 14'h3F00};
  logic        sq_pd   [9] = '{0, 0, 0, 0, 0, 1, 0, 0, 0};

  initial begin
    rst = 1'b1; run = 1'b0; cfg_valid = 1'b0; val_req = 1'b0;
    set_cfg(2'd0, '0, '0, '0);
    tick(); tick();
    chk("rst_dac", dac_val, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", cfg_ready, 1);
    chk("rst_pd", period_done, 0);
    chk("rst_err", cfg_err, 0);
    rst = 1'b0;
    tick();
    chk("post_rst_dac", dac_val, 0);

    // Sawtooth
    send_cfg(2'd1, 14'h1000, 14'h1004, 14'd2);
    run = 1'b1; tick();
    chk("saw_load", dac_val, 14'h1000);
    chk("saw_busy", busy, 1);
    tick();
    chk("saw_noreq", dac_val, 14'h1000);
    do_req(); chk("saw_r1", dac_val, 14'h1002); chk("saw_r1_pd", period_done, 0);
    do_req(); chk("saw_r2", dac_val, 14'h1004); chk("saw_r2_pd", period_done, 0);
    do_req(); chk("saw_r3", dac_val, 14'h1000); chk("saw_r3_pd", period_done, 1);
    tick();   chk("saw_pd_pulse", period_done, 0);
    do_req(); chk("saw_r4", dac_val, 14'h1002);

    // Stop with simultaneous val_req: no step
    run = 1'b0; val_req = 1'b1; tick(); val_req = 1'b0;
    chk("stop_dac", dac_val, 14'h1002);
    chk("stop_busy", busy, 0);

    // Triangle
    send_cfg(2'd2, 14'h1000, 14'h2000, 14'h0700);
    run = 1'b1; tick();
    chk("tri_load", dac_val, 14'h1000);
    for (int i = 0; i < 6; i++) begin
      do_req();
      chk($sformatf("tri_r%0d", i), dac_val, tri_exp[i]);
      chk($sformatf("tri_pd%0d", i), period_done, (i == 5) ? 1 : 0);
    end
    run = 1'b0; tick();

    // Square
    send_cfg(2'd3, 14'h0100, 14'h3F00, 14'd2);
    run = 1'b1; tick();
    chk("sq_load", dac_val, 14'h0100);
    for (int i = 0; i < 9; i++) begin
      do_req();
      chk($sformatf("sq_r%0d", i), dac_val, sq_exp[i]);
      chk($sformatf("sq_pd%0d", i), period_done, sq_pd[i]);
    end
    run = 1'b0; tick();

    // Overflow wraps to lo
    send_cfg(2'd1, 14'h0000, 14'h3FFF, 14'h3000);
    run = 1'b1; tick();
    do_req(); chk("ovf_r1", dac_val, 14'h3000);
    do_req(); chk("ovf_r2", dac_val, 14'h0000); chk("ovf_pd", period_done, 1);
    run = 1'b0; tick();

    // step = 0 holds
    send_cfg(2'd1, 14'h0020, 14'h0030, 14'd0);
    run = 1'b1; tick();
    do_req(); chk("step0_dac", dac_val, 14'h0020); chk("step0_pd", period_done, 0);
    run = 1'b0; tick();

    // Config during run
    send_cfg(2'd1, 14'h0010, 14'h0016, 14'd2);
    run = 1'b1; tick();
    do_req(); chk("cdr_r1", dac_val, 14'h0012);
    send_cfg(2'd1, 14'h0200, 14'h0210, 14'd4);
    chk("cdr_ready_lo", cfg_ready, 0);
    chk("cdr_no_jump", dac_val, 14'h0012);
    do_req(); chk("cdr_r2", dac_val, 14'h0014); chk("cdr_ready_lo2", cfg_ready, 0);
    do_req(); chk("cdr_r3", dac_val, 14'h0016);
    // Offer a config in the apply cycle; it must not be taken.
    set_cfg(2'd1, 14'h0300, 14'h0310, 14'd1);
    cfg_valid = 1'b1;
    do_req();
    cfg_valid = 1'b0;
    chk("cdr_wrap", dac_val, 14'h0200);
    chk("cdr_wrap_pd", period_done, 1);
    chk("cdr_ready_hi", cfg_ready, 1);
    do_req(); chk("cdr_r5", dac_val, 14'h0204);
    // Bad config: lo > hi
    send_cfg(2'd1, 14'd5, 14'd4, 14'd1);
    chk("bad_err", cfg_err, 1);
    chk("bad_ready", cfg_ready, 1);
    tick(); chk("bad_err_pulse", cfg_err, 0);
    do_req(); chk("bad_nochange", dac_val, 14'h0208);

    // Async reset mid-ramp
    #2 rst = 1'b1;
    #1;
    chk("arst_dac", dac_val, 0);
    chk("arst_ready", cfg_ready, 1);
    chk("arst_busy", busy, 0);
    run = 1'b0;
    @(negedge clk); rst = 1'b0;
    tick(); chk("arst_hold", dac_val, 0);
    // Default active config is mode 0 (HOLD) at lo 0
    run = 1'b1; tick();
    chk("def_busy", busy, 1);
    do_req(); chk("def_dac", dac_val, 0); chk("def_pd", period_done, 1);
    run = 1'b0; tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
